// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared phase encoding, lamp bit indices and width helpers for
//               the traffic-light sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        FLASH   = 2'd3
    } phase_t;

    localparam int c_LAMP_Y = 0;
    localparam int c_LAMP_G = 1;
    localparam int c_LAMP_R = 2;

    // Never returns less than 1 so a dwell of 1 still gets a real counter bit
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : dwell_timer
// Description : Loadable down-counter that holds at zero; expired flags zero.
// Revision    : 1.0  initial release
// ============================================================================
module dwell_timer #(
    parameter int             CW      = 5,
    parameter logic [CW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expired
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl
// Description : Round-robin multi-approach traffic-light sequencer with night
//               flashing-yellow mode. Define SENSOR_SKIP_EN for demand-driven
//               approach skipping.
// Revision    : 1.0  initial release
// ============================================================================
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int N_DIR    = 4,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 4,
    parameter int RED_T    = 2,
    parameter int FLASH_T  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     night,
    input  logic [N_DIR-1:0]         req,
    output logic [3*N_DIR-1:0]       light,
    output logic [$clog2(N_DIR)-1:0] active_dir,
    output logic [1:0]               phase
);

    localparam int c_DW    = $clog2(N_DIR);
    localparam int c_MAX_T = max2(max2(GREEN_T, YELLOW_T), max2(RED_T, FLASH_T));
    localparam int c_CW    = clog2(c_MAX_T);

    localparam logic [c_CW-1:0]    c_GREEN_LD  = c_CW'(GREEN_T - 1);
    localparam logic [c_CW-1:0]    c_YELLOW_LD = c_CW'(YELLOW_T - 1);
    localparam logic [c_CW-1:0]    c_RED_LD    = c_CW'(RED_T - 1);
    localparam logic [c_CW-1:0]    c_FLASH_LD  = c_CW'(FLASH_T - 1);
    localparam logic [c_DW-1:0]    c_LAST_DIR  = c_DW'(N_DIR - 1);
    localparam logic [3*N_DIR-1:0] c_ALL_RED_LIGHT = {N_DIR{3'b100}};

    phase_t               phase_q, phase_d;
    logic [c_DW-1:0]      dir_q, dir_d;
    logic                 flash_y_q, flash_y_d;
    logic [3*N_DIR-1:0]   light_q, light_d;

    logic                 w_load;
    logic [c_CW-1:0]      w_load_val;
    logic                 w_expired;
    logic [c_DW-1:0]      w_dir_rr;
    logic [c_DW-1:0]      w_next_dir;

    dwell_timer #(
        .CW      (c_CW),
        .RST_VAL (c_RED_LD)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .expired  (w_expired)
    );

    assign w_dir_rr = (dir_q == c_LAST_DIR) ? '0 : dir_q + c_DW'(1);

`ifdef SENSOR_SKIP_EN
    logic [N_DIR-1:0] pending_q, pending_d;
    logic             started_q, started_d;
    logic             w_found;
    logic [c_DW-1:0]  w_pick;
    logic [c_DW-1:0]  w_idx;

    // Search active_dir+1 upward with wrap; the last probe is active_dir itself
    always_comb begin
        w_found = 1'b0;
        w_pick  = dir_q;
        w_idx   = dir_q;
        for (int k = 1; k <= N_DIR; k++) begin
            w_idx = c_DW'((int'(dir_q) + k) % N_DIR);
            if (!w_found && pending_q[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Before the first green there is nothing to extend, so fall back to round-robin
    assign w_next_dir = w_found ? w_pick : (started_q ? dir_q : w_dir_rr);

    always_comb begin
        pending_d = pending_q | req;
        started_d = started_q;
        if (phase_q == ALL_RED && w_expired && !night) begin
            pending_d[dir_d] = 1'b0;
            started_d        = 1'b1;
        end
    end
`else
    logic w_unused_req;
    assign w_unused_req = ^req;
    assign w_next_dir   = w_dir_rr;
`endif

    always_comb begin
        phase_d    = phase_q;
        dir_d      = dir_q;
        flash_y_d  = flash_y_q;
        w_load     = 1'b0;
        w_load_val = c_RED_LD;
        if (w_expired) begin
            w_load = 1'b1;
            case (phase_q)
                GREEN: begin
                    phase_d    = YELLOW;
                    w_load_val = c_YELLOW_LD;
                end
                YELLOW: begin
                    phase_d    = ALL_RED;
                    w_load_val = c_RED_LD;
                end
                ALL_RED: begin
                    if (night) begin
                        phase_d    = FLASH;
                        flash_y_d  = 1'b1;
                        w_load_val = c_FLASH_LD;
                    end else begin
                        phase_d    = GREEN;
                        dir_d      = w_next_dir;
                        w_load_val = c_GREEN_LD;
                    end
                end
                default: begin
                    if (night) begin
                        flash_y_d  = ~flash_y_q;
                        w_load_val = c_FLASH_LD;
                    end else begin
                        phase_d    = ALL_RED;
                        w_load_val = c_RED_LD;
                    end
                end
            endcase
        end
    end

    // Lamps are decoded from next state so they register in step with the FSM
    always_comb begin
        light_d = '0;
        for (int i = 0; i < N_DIR; i++) begin
            if (phase_d == FLASH) begin
                light_d[3*i + c_LAMP_Y] = flash_y_d;
            end else if (c_DW'(i) == dir_d && phase_d == GREEN) begin
                light_d[3*i + c_LAMP_G] = 1'b1;
            end else if (c_DW'(i) == dir_d && phase_d == YELLOW) begin
                light_d[3*i + c_LAMP_Y] = 1'b1;
            end else begin
                light_d[3*i + c_LAMP_R] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= ALL_RED;
            dir_q     <= c_LAST_DIR;
            flash_y_q <= 1'b0;
            light_q   <= c_ALL_RED_LIGHT;
`ifdef SENSOR_SKIP_EN
            pending_q <= '0;
            started_q <= 1'b0;
`endif
        end else begin
            phase_q   <= phase_d;
            dir_q     <= dir_d;
            flash_y_q <= flash_y_d;
            light_q   <= light_d;
`ifdef SENSOR_SKIP_EN
            pending_q <= pending_d;
            started_q <= started_d;
`endif
        end
    end

    assign light      = light_q;
    assign active_dir = dir_q;
    assign phase      = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_ctrl
// Description : Directed, table-driven bench for traffic_light_ctrl.
//               Define SENSOR_SKIP_EN to exercise demand-driven skipping.
// Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_light_ctrl;

`ifdef SENSOR_SKIP_EN
    localparam int N_DIR = 4;
`else
    localparam int N_DIR = 2;
`endif
    localparam int DW = $clog2(N_DIR);
    localparam logic [3*N_DIR-1:0] ALLR = {N_DIR{3'b100}};

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 night = 1'b0;
    logic [N_DIR-1:0]     req = '0;
    logic [3*N_DIR-1:0]   light;
    logic [DW-1:0]        active_dir;
    logic [1:0]           phase;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .N_DIR    (N_DIR),
        .GREEN_T  (3),
        .YELLOW_T (2),
        .RED_T    (1),
        .FLASH_T  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .night      (night),
        .req        (req),
        .light      (light),
        .active_dir (active_dir),
        .phase      (phase)
    );

    typedef struct {
        logic               nt;
        logic [3*N_DIR-1:0] lt;
        logic [1:0]         ph;
        logic [DW-1:0]      dr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic check_inv();
        int  nonred;
        logic gy;
        nonred = 0;
        gy     = 1'b0;
        for (int i = 0; i < N_DIR; i++) begin
            if (!light[3*i+2]) nonred++;
            if (light[3*i+1] && light[3*i]) gy = 1'b1;
        end
        if (phase != 2'd3) chk("inv_one_nonred", 32'(nonred <= 1), 32'd1);
        chk("inv_g_and_y", 32'(gy), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) check_inv();
    endtask

    task automatic do_reset(input string nm);
        rst   = 1'b1;
        night = 1'b0;
        req   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_light"}, 32'(light), 32'(ALLR));
        chk({nm, "_phase"}, 32'(phase), 32'd0);
        chk({nm, "_dir"},   32'(active_dir), 32'(N_DIR - 1));
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        chk({nm, "_light"}, 32'(light), 32'(v.lt));
        chk({nm, "_phase"}, 32'(phase), 32'(v.ph));
        chk({nm, "_dir"},   32'(active_dir), 32'(v.dr));
        night = v.nt;
        tick();
    endtask

    task automatic go(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

`ifndef SENSOR_SKIP_EN
    localparam logic [5:0] AR = 6'b100_100;
    localparam logic [5:0] G0 = 6'b100_010;
    localparam logic [5:0] Y0 = 6'b100_001;
    localparam logic [5:0] G1 = 6'b010_100;
    localparam logic [5:0] Y1 = 6'b001_100;
    localparam logic [5:0] FN = 6'b001_001;
    localparam logic [5:0] FF = 6'b000_000;

    vec_t t1[16];
    vec_t t3[16];

    initial begin
        bit seen;
        t1[0]  = '{1'b0, AR, 2'd0, 1'b1};
        t1[1]  = '{1'b0, G0, 2'd1, 1'b0};
        t1[2]  = '{1'b0, G0, 2'd1, 1'b0};
        t1[3]  = '{1'b0, G0, 2'd1, 1'b0};
        t1[4]  = '{1'b0, Y0, 2'd2, 1'b0};
        t1[5]  = '{1'b0, Y0, 2'd2, 1'b0};
        t1[6]  = '{1'b0, AR, 2'd0, 1'b0};
        t1[7]  = '{1'b0, G1, 2'd1, 1'b1};
        t1[8]  = '{1'b0, G1, 2'd1, 1'b1};
        t1[9]  = '{1'b0, G1, 2'd1, 1'b1};
        t1[10] = '{1'b0, Y1, 2'd2, 1'b1};
        t1[11] = '{1'b0, Y1, 2'd2, 1'b1};
        t1[12] = '{1'b0, AR, 2'd0, 1'b1};
        t1[13] = '{1'b0, G0, 2'd1, 1'b0};
        t1[14] = '{1'b0, G0, 2'd1, 1'b0};
        t1[15] = '{1'b0, G0, 2'd1, 1'b0};

        // nt is the night level presented on the edge that ends that cycle
        t3[0]  = '{1'b0, AR, 2'd0, 1'b1};
        t3[1]  = '{1'b1, G0, 2'd1, 1'b0};
        t3[2]  = '{1'b1, G0, 2'd1, 1'b0};
        t3[3]  = '{1'b1, G0, 2'd1, 1'b0};
        t3[4]  = '{1'b1, Y0, 2'd2, 1'b0};
        t3[5]  = '{1'b1, Y0, 2'd2, 1'b0};
        t3[6]  = '{1'b1, AR, 2'd0, 1'b0};
        t3[7]  = '{1'b1, FN, 2'd3, 1'b0};
        t3[8]  = '{1'b1, FN, 2'd3, 1'b0};
        t3[9]  = '{1'b1, FF, 2'd3, 1'b0};
        t3[10] = '{1'b1, FF, 2'd3, 1'b0};
        t3[11] = '{1'b0, FN, 2'd3, 1'b0};
        t3[12] = '{1'b0, FN, 2'd3, 1'b0};
        t3[13] = '{1'b0, AR, 2'd0, 1'b0};
        t3[14] = '{1'b0, G1, 2'd1, 1'b1};
        t3[15] = '{1'b0, G1, 2'd1, 1'b1};

        do_reset("t1_rst");
        for (int i = 0; i < 16; i++) run_vec(t1[i], $sformatf("t1_c%0d", i));

        // Reset in the middle of dir1 yellow
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (phase == 2'd2 && active_dir == 1'b1) seen = 1'b1;
            else tick();
        end
        chk("t2_reach_y1", 32'(seen), 32'd1);
        rst = 1'b1;
        tick();
        chk("t2_rst_light", 32'(light), 32'(AR));
        chk("t2_rst_phase", 32'(phase), 32'd0);
        chk("t2_rst_dir",   32'(active_dir), 32'd1);
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 8; i++) run_vec(t1[i], $sformatf("t2_c%0d", i));

        do_reset("t3_rst");
        for (int i = 0; i < 16; i++) run_vec(t3[i], $sformatf("t3_c%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
`else
    task automatic chk_pd(input string nm, input logic [1:0] ph, input logic [DW-1:0] dr);
        chk({nm, "_phase"}, 32'(phase), 32'(ph));
        chk({nm, "_dir"},   32'(active_dir), 32'(dr));
    endtask

    initial begin
        do_reset("t5_rst");
        go(1);  chk_pd("t5_c1_g0", 2'd1, 2'd0);
        go(6);  chk_pd("t5_c6_ar", 2'd0, 2'd0);
        go(7);  chk_pd("t5_c7_regreen0", 2'd1, 2'd0);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        go(12); chk_pd("t5_c12_ar", 2'd0, 2'd0);
        go(13); chk_pd("t5_c13_g2", 2'd1, 2'd2);
        chk("t5_c13_light", 32'(light), 32'(12'b100_010_100_100));

        req = 4'b1010;
        tick();
        req = 4'b0000;
        go(18); chk_pd("t6_c18_ar", 2'd0, 2'd2);
        go(19); chk_pd("t6_c19_g3", 2'd1, 2'd3);
        go(24); chk_pd("t6_c24_ar", 2'd0, 2'd3);
        go(25); chk_pd("t6_c25_g1", 2'd1, 2'd1);
        go(31); chk_pd("t6_c31_extend1", 2'd1, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
`endif

endmodule
`default_nettype wire
